ets_frame_writer: RTL

//  Write-side producer for the 3-bank ETS frame store. Accepts one 32-bit sample per

---
 rtl/ets_fb_pkg.sv | 33 +++
 rtl/ets_bank_pick.sv | 29 ++
 rtl/ets_frame_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ets_fb_pkg.sv
// ets_fb_pkg: shared widths, bank encodings, FSM state type and helpers for the
// ETS frame-store write side.
//   TAP_W   : width of the frame-store write address (taps per frame up to 512)
//   BANK_W  : width of the one-hot bank identifier
//   BANK0..2: one-hot bank constants
//   state_t : writer FSM states
//   rotl3() : rotate a one-hot bank id left by one (001->010->100->001)
//   is_onehot3(): true when exactly one bit of a 3-bit vector is set
package ets_fb_pkg;

  localparam int unsigned TAP_W  = 9;
  localparam int unsigned BANK_W = 3;

  localparam logic [BANK_W-1:0] BANK0 = 3'b001;
  localparam logic [BANK_W-1:0] BANK1 = 3'b010;
  localparam logic [BANK_W-1:0] BANK2 = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WRITE = 2'd2,
    SWAP  = 2'd3
  } state_t;

  function automatic logic [BANK_W-1:0] rotl3(input logic [BANK_W-1:0] x);
    return {x[BANK_W-2:0], x[BANK_W-1]};
  endfunction

  function automatic logic is_onehot3(input logic [BANK_W-1:0] x);
    return (x == BANK0) || (x == BANK1) || (x == BANK2);
  endfunction

endpackage

// File: rtl/ets_bank_pick.sv
// ets_bank_pick: chooses the next bank to write after a frame completes.
//   i_cur  [3] : one-hot bank that was just written
//   i_lock [3] : one-hot bank held by the reader (0 = none; multi-hot = none)
//   o_next [3] : one-hot bank to write next; never the current or a valid locked bank
// Purely combinational.
module ets_bank_pick
  import ets_fb_pkg::*;
(
  input  logic [BANK_W-1:0] i_cur,
  input  logic [BANK_W-1:0] i_lock,
  output logic [BANK_W-1:0] o_next
);

  logic [BANK_W-1:0] w_lock_eff;
  logic [BANK_W-1:0] w_cand;

  always_comb begin
    // A malformed (multi-hot) lock carries no information; ignore it.
    w_lock_eff = is_onehot3(i_lock) ? i_lock : '0;
    w_cand     = ~i_cur & ~w_lock_eff;
    // Single free bank: take it. Two free banks (no lock, or lock on cur): rotate.
    if (is_onehot3(w_cand)) begin
      o_next = w_cand;
    end else begin
      o_next = rotl3(i_cur);
    end
  end

endmodule

// File: rtl/ets_frame_writer.sv
// ets_frame_writer: write-side producer for the 3-bank ETS frame store.
// After a trigger it accepts MAX_TAP samples over a valid/ready handshake, writes
// them to consecutive taps of the current bank, publishes that bank as the latest
// complete frame and rotates to a bank the reader is not holding.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : 1 = run, 0 = abort and hold idle
//   trigger           : single-cycle frame start pulse
//   s_valid/s_data    : sample stream in; s_ready out
//   rd_lock_id [3]    : one-hot bank held by the reader (0 = none)
//   waddr/wdata       : frame-store write address/data, w_occur write strobe
//   w_buffer_id [3]   : one-hot bank being written
//   done_id [3]       : one-hot latest completed bank, frame_done pulse on update
//   frame_count [16]  : completed frames (wrapping)
//   overrun           : sticky, trigger seen outside ARM
module ets_frame_writer
  import ets_fb_pkg::*;
#(
  parameter int unsigned MAX_TAP = 448
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              trigger,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  input  logic [BANK_W-1:0] rd_lock_id,
  output logic [TAP_W-1:0]  waddr,
  output logic [31:0]       wdata,
  output logic [BANK_W-1:0] w_buffer_id,
  output logic              w_occur,
  output logic [BANK_W-1:0] done_id,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              overrun
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(MAX_TAP - 1);

  state_t            r_state;
  logic [TAP_W-1:0]  r_tap;
  logic              r_s_ready;
  logic [TAP_W-1:0]  r_waddr;
  logic [31:0]       r_wdata;
  logic [BANK_W-1:0] r_w_buffer_id;
  logic              r_w_occur;
  logic [BANK_W-1:0] r_done_id;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic              r_overrun;

  logic [BANK_W-1:0] w_next_id;
  logic              w_hs;

  ets_bank_pick u_bank_pick (
    .i_cur  (r_w_buffer_id),
    .i_lock (rd_lock_id),
    .o_next (w_next_id)
  );

  assign w_hs = s_valid & r_s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_tap         <= '0;
      r_s_ready     <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_w_buffer_id <= BANK0;
      r_w_occur     <= 1'b0;
      r_done_id     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_w_occur    <= 1'b0;
      r_frame_done <= 1'b0;
      if (!enable) begin
        // Abort: drop the partial frame; bank, done_id and count are kept so the
        // next frame rewrites the same bank from tap 0.
        r_state   <= IDLE;
        r_s_ready <= 1'b0;
        r_overrun <= 1'b0;
      end else begin
        if (trigger && (r_state != ARM)) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            r_s_ready <= 1'b0;
            r_state   <= ARM;
          end
          ARM: begin
            r_tap <= '0;
            if (trigger) begin
              r_state   <= WRITE;
              r_s_ready <= 1'b1;
            end
          end
          WRITE: begin
            if (w_hs) begin
              r_waddr   <= r_tap;
              r_wdata   <= s_data;
              r_w_occur <= 1'b1;
              r_tap     <= r_tap + 1'b1;
              if (r_tap == LAST_TAP) begin
                r_s_ready <= 1'b0;
                r_state   <= SWAP;
              end
            end
          end
          SWAP: begin
            r_done_id     <= r_w_buffer_id;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_w_buffer_id <= w_next_id;
            r_state       <= ARM;
          end
          default: begin
            r_state   <= IDLE;
            r_s_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign waddr       = r_waddr;
  assign wdata       = r_wdata;
  assign w_buffer_id = r_w_buffer_id;
  assign w_occur     = r_w_occur;
  assign done_id     = r_done_id;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;

endmodule
